// File: rtl/sub_64bit_pipe.sv
// Pipelined unsigned subtractor: one SLICE-bit slice per stage, borrow registered between stages.
// Latency NSTAGE enabled cycles, one op per enabled cycle; en=0 freezes every register, no other backpressure.
module sub_64bit_pipe #(
  parameter int WIDTH  = 64,
  parameter int SLICE  = 8,
  parameter int NSTAGE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in_a,
  input  logic [WIDTH-1:0] data_in_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  // Operand skew: each entry holds the not-yet-consumed slices, next slice in the low bits.
  logic [WIDTH-1:0] a_skew [NSTAGE-1];
  logic [WIDTH-1:0] b_skew [NSTAGE-1];

  // Result deskew: finished slices enter at the top and shift down one slice per stage.
  logic [WIDTH-1:0] d_q  [NSTAGE];
  logic             bo_q [NSTAGE];
  logic             z_q  [NSTAGE];
  logic             v_q  [NSTAGE];

  // {borrow_out, diff_slice} for each stage, 9-bit arithmetic for the default slice size
  logic [SLICE:0]   sub  [NSTAGE];

  genvar s;
  for (s = 0; s < NSTAGE; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign sub[s] = {1'b0, data_in_a[SLICE-1:0]} - {1'b0, data_in_b[SLICE-1:0]};
    end else begin : g_body
      assign sub[s] = {1'b0, a_skew[s-1][SLICE-1:0]}
                    - {1'b0, b_skew[s-1][SLICE-1:0]}
                    - {{SLICE{1'b0}}, bo_q[s-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSTAGE; i++) begin
        d_q[i]  <= '0;
        bo_q[i] <= 1'b0;
        z_q[i]  <= 1'b0;
        v_q[i]  <= 1'b0;
      end
      for (int i = 0; i < NSTAGE-1; i++) begin
        a_skew[i] <= '0;
        b_skew[i] <= '0;
      end
    end else if (en) begin
      v_q[0]  <= in_valid;
      bo_q[0] <= sub[0][SLICE];
      z_q[0]  <= (sub[0][SLICE-1:0] == '0);
      d_q[0]  <= {sub[0][SLICE-1:0], {(WIDTH-SLICE){1'b0}}};
      for (int i = 1; i < NSTAGE; i++) begin
        v_q[i]  <= v_q[i-1];
        bo_q[i] <= sub[i][SLICE];
        z_q[i]  <= z_q[i-1] & (sub[i][SLICE-1:0] == '0);
        d_q[i]  <= {sub[i][SLICE-1:0], d_q[i-1][WIDTH-1:SLICE]};
      end
      a_skew[0] <= data_in_a >> SLICE;
      b_skew[0] <= data_in_b >> SLICE;
      for (int i = 1; i < NSTAGE-1; i++) begin
        a_skew[i] <= a_skew[i-1] >> SLICE;
        b_skew[i] <= b_skew[i-1] >> SLICE;
      end
    end
  end

  assign out_valid = v_q[NSTAGE-1];
  assign diff      = d_q[NSTAGE-1];
  assign borrow    = bo_q[NSTAGE-1];
  assign zero      = z_q[NSTAGE-1];

endmodule
